// File: rtl/stack_cpu_ctrl_pkg.sv
// Shared definitions for the stack-machine controller: opcodes, ALU encodings
// and the controller state type. Optional STACK_CPU_CTRL_STEP_EN adds HALT.
package stack_cpu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_PUSH = 3'b100;
  localparam logic [2:0] OP_POP  = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_JZ   = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_PCINC  = 4'd1,
    S_DECODE = 4'd2,
    S_POPA2  = 4'd3,
    S_POPB   = 4'd4,
    S_POPA1  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_MEMRD  = 4'd8,
    S_PUSHWB = 4'd9,
    S_POPW   = 4'd10,
    S_MEMWR  = 4'd11,
    S_JUMP   = 4'd12,
    S_POPZ   = 4'd13,
`ifdef STACK_CPU_CTRL_STEP_EN
    S_JZCHK  = 4'd14,
    S_HALT   = 4'd15
`else
    S_JZCHK  = 4'd14
`endif
  } ctrl_state_t;

endpackage

// File: rtl/stack_cpu_ctrl_if.sv
// Controller <-> datapath bundle: opcode/zero in, strobes and selects out.
// master = controller, slave = datapath. STACK_CPU_CTRL_STEP_EN adds step/halted.
interface stack_cpu_ctrl_if;
  logic [2:0] inst;
  logic       zero;
  logic       ld_IR;
  logic       PCorIR;
  logic       push;
  logic       pop;
  logic       MEMorALU;
  logic       ldA;
  logic       ldB;
  logic       PCup;
  logic       PCwrite;
  logic       J;
  logic       JZ;
  logic       write_enable;
  logic [1:0] ALUop;
`ifdef STACK_CPU_CTRL_STEP_EN
  logic       step;
  logic       halted;
`endif

  modport master (
`ifdef STACK_CPU_CTRL_STEP_EN
    input  step,
    output halted,
`endif
    input  inst, zero,
    output ld_IR, PCorIR, push, pop, MEMorALU,
    output ldA, ldB, PCup, PCwrite, J, JZ,
    output write_enable, ALUop
  );

  modport slave (
`ifdef STACK_CPU_CTRL_STEP_EN
    output step,
    input  halted,
`endif
    output inst, zero,
    input  ld_IR, PCorIR, push, pop, MEMorALU,
    input  ldA, ldB, PCup, PCwrite, J, JZ,
    input  write_enable, ALUop
  );
endinterface

// File: rtl/stack_cpu_ctrl.sv
// Multicycle Moore controller for the 8-bit stack datapath (clk, rst, bus).
// Optional STACK_CPU_CTRL_STEP_EN: single-step via bus.step / bus.halted.
module stack_cpu_ctrl
  import stack_cpu_pkg::*;
#(
  parameter int MEM_WAIT = 0
) (
  input  logic             clk,
  input  logic             rst,
  stack_cpu_ctrl_if.master bus
);

  localparam logic [2:0] WAIT_N = 3'(MEM_WAIT);

`ifdef STACK_CPU_CTRL_STEP_EN
  localparam ctrl_state_t RST_ST  = S_HALT;
  localparam ctrl_state_t DONE_ST = S_HALT;
`else
  localparam ctrl_state_t RST_ST  = S_FETCH;
  localparam ctrl_state_t DONE_ST = S_FETCH;
`endif

  ctrl_state_t state, state_nx;
  logic [2:0]  cnt, cnt_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RST_ST;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx         = S_FETCH;
    cnt_nx           = '0;
    bus.ld_IR        = 1'b0;
    bus.PCorIR       = 1'b0;
    bus.push         = 1'b0;
    bus.pop          = 1'b0;
    bus.MEMorALU     = 1'b0;
    bus.ldA          = 1'b0;
    bus.ldB          = 1'b0;
    bus.PCup         = 1'b0;
    bus.PCwrite      = 1'b0;
    bus.J            = 1'b0;
    bus.JZ           = 1'b0;
    bus.write_enable = 1'b0;
    bus.ALUop        = ALU_ADD;
`ifdef STACK_CPU_CTRL_STEP_EN
    bus.halted       = 1'b0;
`endif
    case (state)
      S_FETCH: begin
        bus.ld_IR = 1'b1;
        bus.PCup  = 1'b1;
        // Counter only runs while memory is slow; cleared on exit.
        if (cnt == WAIT_N) begin
          state_nx = S_PCINC;
        end else begin
          state_nx = S_FETCH;
          cnt_nx   = cnt + 3'd1;
        end
      end
      S_PCINC: begin
        bus.PCwrite = 1'b1;
        state_nx    = S_DECODE;
      end
      S_DECODE: begin
        case (bus.inst)
          OP_ADD, OP_SUB, OP_AND: state_nx = S_POPA2;
          OP_NOT:  state_nx = S_POPA1;
          OP_PUSH: state_nx = S_MEMRD;
          OP_POP:  state_nx = S_POPW;
          OP_JMP:  state_nx = S_JUMP;
          default: state_nx = S_POPZ;
        endcase
      end
      S_POPA2: begin
        bus.pop  = 1'b1;
        bus.ldA  = 1'b1;
        state_nx = S_POPB;
      end
      S_POPB: begin
        bus.pop  = 1'b1;
        bus.ldB  = 1'b1;
        state_nx = S_EXEC;
      end
      S_POPA1: begin
        bus.pop  = 1'b1;
        bus.ldA  = 1'b1;
        state_nx = S_EXEC;
      end
      S_EXEC: begin
        bus.ALUop = bus.inst[1:0];
        state_nx  = S_ALUWB;
      end
      S_ALUWB: begin
        bus.ALUop    = bus.inst[1:0];
        bus.MEMorALU = 1'b1;
        bus.push     = 1'b1;
        state_nx     = DONE_ST;
      end
      S_MEMRD: begin
        bus.PCorIR = 1'b1;
        if (cnt == WAIT_N) begin
          state_nx = S_PUSHWB;
        end else begin
          state_nx = S_MEMRD;
          cnt_nx   = cnt + 3'd1;
        end
      end
      S_PUSHWB: begin
        bus.push = 1'b1;
        state_nx = DONE_ST;
      end
      S_POPW: begin
        bus.pop  = 1'b1;
        bus.ldA  = 1'b1;
        state_nx = S_MEMWR;
      end
      S_MEMWR: begin
        bus.PCorIR       = 1'b1;
        bus.write_enable = 1'b1;
        state_nx         = DONE_ST;
      end
      S_JUMP: begin
        bus.J       = 1'b1;
        bus.PCwrite = 1'b1;
        state_nx    = DONE_ST;
      end
      S_POPZ: begin
        bus.pop  = 1'b1;
        bus.ldA  = 1'b1;
        state_nx = S_JZCHK;
      end
      S_JZCHK: begin
        bus.JZ      = 1'b1;
        bus.PCwrite = bus.zero;
        state_nx    = DONE_ST;
      end
`ifdef STACK_CPU_CTRL_STEP_EN
      S_HALT: begin
        bus.halted = 1'b1;
        state_nx   = bus.step ? S_FETCH : S_HALT;
      end
`endif
      default: state_nx = S_FETCH;
    endcase
  end

endmodule

// File: doc/stack_cpu_ctrl.md
Name: stack_cpu_ctrl

Overview:
- Multicycle Moore FSM that sequences the 8-bit stack-machine datapath: fetch, PC increment, decode, then per-opcode operand/ALU/memory/jump steps.
- Consumes opcode `inst` (IR[7:5]) and the datapath zero flag (A==0).
- Drives every datapath strobe and mux select.
- Controller updates on posedge clk. The datapath registers on negedge, so strobes are stable for half a cycle before use.

Parameters:
- MEM_WAIT, 0, extra cycles held in FETCH and MEMRD for slow memory (0..7).

Ports:
- clk  in  1  system clock, posedge
- rst  in  1  asynchronous, active-high reset
- inst  in  3  opcode = IR[7:5]
- zero  in  1  datapath A==0 flag
- ld_IR  out  1  load IR from memory
- PCorIR  out  1  memory address select: 1=IR[4:0], 0=PC
- push  out  1  push ALUorMEM onto stack
- pop  out  1  pop stack
- MEMorALU  out  1  stack input select: 1=ALUres, 0=MDR
- ldA  out  1  load A from stack top
- ldB  out  1  load B from stack top
- PCup  out  1  ALU operands = PC, 1
- PCwrite  out  1  load PC
- J  out  1  unconditional jump select
- JZ  out  1  conditional jump select
- write_enable  out  1  memory write of A to IR[4:0]
- ALUop  out  2  00 add, 01 sub, 10 and, 11 not(A)

Behaviour:
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH, 101 POP, 110 JMP, 111 JZ.
- Outputs are a pure decode of state. Any strobe not listed for a state is 0; ALUop defaults to 00.

States and outputs:
- FETCH: PCorIR=0, ld_IR=1, PCup=1, ALUop=00.
  - Wait counter clears on entry and increments each cycle.
  - Leave when count==MEM_WAIT, to PCINC.
- PCINC: PCwrite=1 (J=JZ=0, so PC<=PC+1) -> DECODE.
- DECODE: no strobes.
  - ADD/SUB/AND -> POPA2.
  - NOT -> POPA1.
  - PUSH -> MEMRD.
  - POP -> POPW.
  - JMP -> JUMP.
  - JZ -> POPZ.
- POPA2: pop=1, ldA=1 -> POPB.
- POPB: pop=1, ldB=1 -> EXEC.
- POPA1: pop=1, ldA=1 -> EXEC.
- EXEC: ALUop=inst[1:0], PCup=0 -> ALUWB.
- ALUWB: ALUop held, MEMorALU=1, push=1 -> FETCH.
- MEMRD: PCorIR=1; MEM_WAIT counter as in FETCH -> PUSHWB.
- PUSHWB: MEMorALU=0, push=1 -> FETCH.
- POPW: pop=1, ldA=1 -> MEMWR.
- MEMWR: PCorIR=1, write_enable=1 -> FETCH.
- JUMP: J=1, PCwrite=1 -> FETCH.
- POPZ: pop=1, ldA=1 -> JZCHK.
- JZCHK: JZ=1, PCwrite=zero -> FETCH. Not taken means PC is unchanged.

Latencies (MEM_WAIT=0, counted FETCH to next FETCH):
- ADD/SUB/AND: 7 cycles.
- NOT: 6 cycles.
- PUSH and POP: 5 cycles.
- JMP: 4 cycles.
- JZ: 5 cycles.

Reset and invariants:
- rst asserted at any time, including mid-instruction, forces state=FETCH and wait counter=0 asynchronously.
- Outputs during reset equal the FETCH decode: ld_IR=1, PCup=1, PCorIR=0, ALUop=00, all others 0.
- An aborted instruction leaves no pending strobe.
- push and pop are never asserted in the same state.
- write_enable is asserted only in MEMWR.
- PCwrite is asserted only in PCINC, JUMP and JZCHK.
- Unreachable state encodings go to FETCH.

Optional Feature:
- Macro: STACK_CPU_CTRL_STEP_EN.
- Defined:
  - Adds input `step` (1) and output `halted` (1).
  - Adds state HALT, the reset state; all strobes 0 and halted=1 in HALT.
  - HALT goes to FETCH on a cycle with step=1.
  - Every instruction's final state returns to HALT instead of FETCH, giving one instruction per step pulse.
  - step held high runs continuously, with one HALT cycle between instructions.
- Undefined: no extra ports or state; behaviour exactly as above.

Decomposition:
- Package stack_cpu_pkg holds:
  - opcode localparams (OP_ADD..OP_JZ);
  - ALUop encodings (ALU_ADD, ALU_SUB, ALU_AND, ALU_NOT);
  - typedef enum logic [3:0] ctrl_state_t.
- No sub-module needed. Wait counter and next-state/output decode stay inline as two always blocks plus one state register.

Test Plan:
- Reset:
  - Pulse rst mid-EXEC with MEM_WAIT=0 -> next sampled state is FETCH.
  - During reset ld_IR=1, PCup=1, all other strobes 0, ALUop=00.
- ADD:
  - inst=000 -> over 7 cycles see ld_IR, PCwrite, idle, pop+ldA, pop+ldB, ALUop=00, then push+MEMorALU=1 with ALUop=00 -> FETCH.
  - Repeat with inst=001 and 010: ALUop=01 and 10 in EXEC/ALUWB.
- NOT and PUSH:
  - inst=011 -> single pop+ldA, then ALUop=11, then push; 6 cycles total.
  - inst=100 -> PCorIR=1, then push with MEMorALU=0; 5 cycles.
- POP / JMP:
  - inst=101 -> pop+ldA, then write_enable=1 with PCorIR=1.
  - inst=110 -> J=1 and PCwrite=1 in the same cycle; 4 cycles.
- JZ:
  - inst=111 with zero=1 -> JZCHK shows JZ=1, PCwrite=1.
  - With zero=0 -> JZ=1, PCwrite=0.
- MEM_WAIT=2:
  - FETCH lasts 3 cycles with ld_IR held.
  - MEMRD lasts 3 cycles.
  - PUSH total is 9 cycles.
